em_stage: RTL and testbench
===========================

Name: em_stage

Overview:
- Execute→memory pipeline stage: consumes the DE register's execute-stage outputs plus the ALU result, holds the E/M pipeline register, sequences the data-memory access, and feeds the write-back stage.
- Supports variable-latency data memory through a ready handshake.
- While an access is outstanding, asserts a stall that freezes the upstream stages and inserts bubbles toward write-back.

Parameters:
TIMEOUT, 15, max wait cycles before abort (used only with MEM_TIMEOUT_EN)
WCNT_W, 16, width of saturating wait-cycle performance counter

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous active-low reset
EMFlush  in  1  synchronous flush of E/M register
WEN_E, Load_E, DRW_E, DREQ_E  in  1 each  execute control (WEN/DREQ active-low; DRW 1=write)
SelWB_E  in  2  write-back select
WA_E  in  5  destination register
ALUOUT_E, DOUT1_E, PCADD4_E  in  32 each  ALU result / store data / PC+4
DREQ  out  1  data-memory request, active-low
DRW  out  1  1=write, 0=read
DADDR, DWDATA  out  32 each  memory address / write data
DRDATA  in  32  memory read data
DRDY  in  1  memory ready; completes access in the cycle it is high
StallM  out  1  hold fetch/decode/execute and DE register
WEN_W  out  1  register-file write enable, active-low
SelWB_W  out  2
WA_W  out  5
ALUOUT_W, RDATA_W, PCADD4_W  out  32 each
WaitCycles  out  WCNT_W  cumulative stall cycles, saturating
MemErr  out  1  sticky timeout flag (MEM_TIMEOUT_EN only, else 0)

Behaviour:
- Reset (RSTN low, async): E/M register cleared; DREQ=1, WEN_W=1, DRW=0; all other outputs 0; state IDLE; counters 0. Mid-access reset drops DREQ immediately and abandons the access.
- E/M register: when StallM=0, captures all _E inputs each rising edge. Captured values drive DREQ/DRW/DADDR(=ALUOUT)/DWDATA(=DOUT1) directly.
- EMFlush with StallM=0: loads bubble (WEN=1, DREQ=1, other fields 0). EMFlush with StallM=1: ignored; the outstanding access completes.
- States:
  - IDLE: no request.
  - ACCESS: registered DREQ=0.
  - An access is in ACCESS from capture until the cycle DRDY=1.
- StallM = (DREQ==0) & ~DRDY, combinational. Zero-wait access (DRDY high in first cycle) never stalls.
- While stalling:
  - DREQ, DRW, DADDR, and DWDATA are held stable.
  - The W outputs receive a bubble each edge (WEN_W=1).
  - WaitCycles increments by 1 each edge and saturates at all-ones.
- Completion edge (DRDY=1 or no request):
  - W register loads WEN_W, SelWB_W, WA_W, ALUOUT_W, PCADD4_W from the M fields.
  - RDATA_W loads DRDATA for a read, or 0 for a write or no access.
  - The E/M register simultaneously captures the next instruction (back-to-back accesses allowed, no idle cycle).
- DRDY high while DREQ=1 is ignored.
- Internal wait counter resets to 0 on each completion; width is ceil(log2(TIMEOUT+1)).

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - If the wait counter reaches TIMEOUT with DRDY still low, the access is aborted on that edge.
  - StallM is released; the W register loads with RDATA_W=0.
  - MemErr is set and stays set until reset.
- Undefined:
  - No timeout; the stage waits indefinitely.
  - MemErr is tied 0; the TIMEOUT parameter is unused.

Test Plan:
- Reset: pulse RSTN low mid-cycle → DREQ=1, WEN_W=1, StallM=0, WaitCycles=0 immediately, without a clock edge.
- Zero-wait load: DREQ_E=0, DRW_E=0, ALUOUT_E=0x100, DRDY=1, DRDATA=0xDEADBEEF → DADDR=0x100 one cycle after capture; next edge RDATA_W=0xDEADBEEF, WEN_W=WEN_E; StallM never 1.
- 3-wait store: DRW_E=1, DOUT1_E=0x12345678, DRDY low 3 cycles → StallM high exactly 3 cycles; DWDATA/DADDR stable; 3 bubbles on WEN_W; WaitCycles=3; RDATA_W=0.
- Flush: EMFlush while idle → W bubble next cycle. EMFlush during a 2-wait load → ignored; load data still written back.
- Back-to-back: two loads with DRDY=1 → DREQ low for 2 consecutive cycles; both results appear on consecutive cycles.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT=15): DRDY held 0 → StallM high 15 cycles then low; MemErr=1 sticky; RDATA_W=0. Async reset mid-wait → MemErr=0, DREQ=1.

Source files
------------

// File: rtl/em_stage_if.sv
// Data-memory port of the E/M stage: request/address/write data out, read data and ready back.
// The master side is the pipeline stage, the slave side is the memory.
interface em_stage_if;
    logic        DREQ;
    logic        DRW;
    logic [31:0] DADDR;
    logic [31:0] DWDATA;
    logic [31:0] DRDATA;
    logic        DRDY;

    modport master (output DREQ, DRW, DADDR, DWDATA, input DRDATA, DRDY);
    modport slave  (input DREQ, DRW, DADDR, DWDATA, output DRDATA, DRDY);
endinterface

// File: rtl/em_stage.sv
// E/M pipeline register and data-memory sequencer feeding write-back; optional MEM_TIMEOUT_EN aborts stuck accesses.
// Latency: one edge into M, one edge into W, plus any memory wait states.
// Backpressure: StallM holds upstream while an access waits for DRDY; W receives bubbles meanwhile.
module em_stage #(
    parameter int TIMEOUT = 15,
    parameter int WCNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              EMFlush,
    input  logic              WEN_E,
    input  logic              Load_E,
    input  logic              DRW_E,
    input  logic              DREQ_E,
    input  logic [1:0]        SelWB_E,
    input  logic [4:0]        WA_E,
    input  logic [31:0]       ALUOUT_E,
    input  logic [31:0]       DOUT1_E,
    input  logic [31:0]       PCADD4_E,
    em_stage_if.master        mem,
    output logic              StallM,
    output logic              WEN_W,
    output logic [1:0]        SelWB_W,
    output logic [4:0]        WA_W,
    output logic [31:0]       ALUOUT_W,
    output logic [31:0]       RDATA_W,
    output logic [31:0]       PCADD4_W,
    output logic [WCNT_W-1:0] WaitCycles,
    output logic              MemErr
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q;
    logic              wen_m_q, drw_m_q;
    logic [1:0]        sel_m_q;
    logic [4:0]        wa_m_q;
    logic [31:0]       alu_m_q, dout_m_q, pc_m_q;
    logic              wen_w_q;
    logic [1:0]        sel_w_q;
    logic [4:0]        wa_w_q;
    logic [31:0]       alu_w_q, rdata_w_q, pc_w_q;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic [TW-1:0]     wcnt_q, wcnt_d;
    logic              memerr_q;
    logic              timeout, advance, rd_access;

    // Read vs write is fully encoded by DREQ/DRW, so the load flag carries no extra information.
    logic unused_load;
    assign unused_load = Load_E;

`ifdef MEM_TIMEOUT_EN
    assign timeout = (state_q == ACCESS) && !mem.DRDY && (wcnt_q == TW'(TIMEOUT));
`else
    logic unused_wcnt;
    assign unused_wcnt = ^wcnt_q;
    assign timeout     = 1'b0;
`endif

    assign StallM    = (state_q == ACCESS) && !mem.DRDY && !timeout;
    assign advance   = !StallM;
    assign rd_access = (state_q == ACCESS) && !drw_m_q && !timeout;

    assign wait_d = (wait_q == {WCNT_W{1'b1}}) ? wait_q : wait_q + 1'b1;
    assign wcnt_d = (wcnt_q == {TW{1'b1}})     ? wcnt_q : wcnt_q + 1'b1;

    assign mem.DREQ   = (state_q != ACCESS);
    assign mem.DRW    = drw_m_q;
    assign mem.DADDR  = alu_m_q;
    assign mem.DWDATA = dout_m_q;

    assign WEN_W      = wen_w_q;
    assign SelWB_W    = sel_w_q;
    assign WA_W       = wa_w_q;
    assign ALUOUT_W   = alu_w_q;
    assign RDATA_W    = rdata_w_q;
    assign PCADD4_W   = pc_w_q;
    assign WaitCycles = wait_q;
    assign MemErr     = memerr_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            wen_m_q   <= 1'b1;
            drw_m_q   <= 1'b0;
            sel_m_q   <= '0;
            wa_m_q    <= '0;
            alu_m_q   <= '0;
            dout_m_q  <= '0;
            pc_m_q    <= '0;
            wen_w_q   <= 1'b1;
            sel_w_q   <= '0;
            wa_w_q    <= '0;
            alu_w_q   <= '0;
            rdata_w_q <= '0;
            pc_w_q    <= '0;
            wait_q    <= '0;
            wcnt_q    <= '0;
            memerr_q  <= 1'b0;
        end else if (advance) begin
            // Retire M into W and refill M in the same edge, so accesses can run back to back.
            wen_w_q   <= wen_m_q;
            sel_w_q   <= sel_m_q;
            wa_w_q    <= wa_m_q;
            alu_w_q   <= alu_m_q;
            pc_w_q    <= pc_m_q;
            rdata_w_q <= rd_access ? mem.DRDATA : 32'd0;
            wcnt_q    <= '0;
            if (timeout) memerr_q <= 1'b1;
            if (EMFlush) begin
                state_q  <= IDLE;
                wen_m_q  <= 1'b1;
                drw_m_q  <= 1'b0;
                sel_m_q  <= '0;
                wa_m_q   <= '0;
                alu_m_q  <= '0;
                dout_m_q <= '0;
                pc_m_q   <= '0;
            end else begin
                state_q  <= DREQ_E ? IDLE : ACCESS;
                wen_m_q  <= WEN_E;
                drw_m_q  <= DRW_E;
                sel_m_q  <= SelWB_E;
                wa_m_q   <= WA_E;
                alu_m_q  <= ALUOUT_E;
                dout_m_q <= DOUT1_E;
                pc_m_q   <= PCADD4_E;
            end
        end else begin
            wen_w_q   <= 1'b1;
            sel_w_q   <= '0;
            wa_w_q    <= '0;
            alu_w_q   <= '0;
            rdata_w_q <= '0;
            pc_w_q    <= '0;
            wait_q    <= wait_d;
            wcnt_q    <= wcnt_d;
        end
    end
endmodule

// File: tb/tb_em_stage.sv
// Bench for em_stage: instruction-level reference model with a memory of per-access latency.
`timescale 1ns/1ps
module tb_em_stage;
    localparam int TIMEOUT = 15;
    localparam int WCNT_W  = 6;
    localparam int WMAX    = (1 << WCNT_W) - 1;

    logic CLK = 1'b0;
    logic RSTN = 1'b1;
    logic EMFlush, WEN_E, Load_E, DRW_E, DREQ_E;
    logic [1:0]  SelWB_E;
    logic [4:0]  WA_E;
    logic [31:0] ALUOUT_E, DOUT1_E, PCADD4_E;
    logic StallM, WEN_W, MemErr;
    logic [1:0]  SelWB_W;
    logic [4:0]  WA_W;
    logic [31:0] ALUOUT_W, RDATA_W, PCADD4_W;
    logic [WCNT_W-1:0] WaitCycles;

    em_stage_if bus();

    em_stage #(.TIMEOUT(TIMEOUT), .WCNT_W(WCNT_W)) dut (
        .CLK(CLK), .RSTN(RSTN), .EMFlush(EMFlush),
        .WEN_E(WEN_E), .Load_E(Load_E), .DRW_E(DRW_E), .DREQ_E(DREQ_E),
        .SelWB_E(SelWB_E), .WA_E(WA_E), .ALUOUT_E(ALUOUT_E), .DOUT1_E(DOUT1_E), .PCADD4_E(PCADD4_E),
        .mem(bus), .StallM(StallM),
        .WEN_W(WEN_W), .SelWB_W(SelWB_W), .WA_W(WA_W), .ALUOUT_W(ALUOUT_W),
        .RDATA_W(RDATA_W), .PCADD4_W(PCADD4_W), .WaitCycles(WaitCycles), .MemErr(MemErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wen, drw, dreq;
        logic [1:0]  sel;
        logic [4:0]  wa;
        logic [31:0] alu, dout, pc;
        int          lat;
    } ins_t;

    int checks = 0;
    int failures = 0;

    // Reference state: instruction held in M, wait edges so far, expected W/counter values.
    ins_t        m;
    int          waited;
    logic        e_wen;
    logic [1:0]  e_sel;
    logic [4:0]  e_wa;
    logic [31:0] e_alu, e_rd, e_pc;
    bit          e_bub;
    int          e_wait;
    bit          e_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t bubble();
        ins_t b;
        b.wen = 1'b1; b.drw = 1'b0; b.dreq = 1'b1; b.sel = 2'd0; b.wa = 5'd0;
        b.alu = 32'd0; b.dout = 32'd0; b.pc = 32'd0; b.lat = 0;
        return b;
    endfunction

    function automatic ins_t rand_ins(input int maxlat);
        ins_t r;
        r.wen  = 1'($urandom_range(0, 1));
        r.dreq = ($urandom_range(0, 3) == 0);
        r.drw  = 1'($urandom_range(0, 1));
        r.sel  = 2'($urandom_range(0, 3));
        r.wa   = 5'($urandom_range(0, 31));
        r.alu  = $urandom;
        r.dout = $urandom;
        r.pc   = $urandom;
        r.lat  = $urandom_range(0, maxlat);
        return r;
    endfunction

    function automatic ins_t mem_ins(input logic drw, input logic [31:0] addr, input logic [31:0] wd, input int lat);
        ins_t r;
        r = rand_ins(0);
        r.dreq = 1'b0; r.drw = drw; r.alu = addr; r.dout = wd; r.lat = lat;
        return r;
    endfunction

    task automatic drive(input ins_t d, input bit f);
        WEN_E = d.wen; DRW_E = d.drw; DREQ_E = d.dreq; Load_E = !d.dreq && !d.drw;
        SelWB_E = d.sel; WA_E = d.wa; ALUOUT_E = d.alu; DOUT1_E = d.dout; PCADD4_E = d.pc;
        EMFlush = f;
    endtask

    task automatic model_reset();
        m = bubble(); waited = 0;
        e_wen = 1'b1; e_sel = 2'd0; e_wa = 5'd0; e_alu = 32'd0; e_rd = 32'd0; e_pc = 32'd0;
        e_bub = 1'b0; e_wait = 0; e_err = 1'b0;
    endtask

    // One clock: memory answers after m.lat wait cycles; E inputs are garbage while stalled.
    task automatic run_cycle(input ins_t e, input bit fl, output bit consumed);
        bit acc, stall, tmo, f;
        ins_t d;
        logic [31:0] rd;
        acc = !m.dreq;
        tmo = 1'b0;
`ifdef MEM_TIMEOUT_EN
        tmo = acc && (waited >= TIMEOUT) && (waited < m.lat);
`endif
        stall = acc && (waited < m.lat) && !tmo;
        @(negedge CLK);
        rd = $urandom;
        bus.DRDATA = rd;
        bus.DRDY = acc ? (waited == m.lat) : 1'($urandom_range(0, 1));
        d = stall ? rand_ins(0) : e;
        f = stall ? 1'($urandom_range(0, 1)) : fl;
        drive(d, f);
        #1;
        check("DREQ", bus.DREQ, m.dreq);
        check("DRW", bus.DRW, m.drw);
        check("DADDR", bus.DADDR, m.alu);
        check("DWDATA", bus.DWDATA, m.dout);
        check("StallM", StallM, stall);
        check("WEN_W", WEN_W, e_wen);
        if (!e_bub) begin
            check("SelWB_W", SelWB_W, e_sel);
            check("WA_W", WA_W, e_wa);
            check("ALUOUT_W", ALUOUT_W, e_alu);
            check("RDATA_W", RDATA_W, e_rd);
            check("PCADD4_W", PCADD4_W, e_pc);
        end
        check("WaitCycles", WaitCycles, 64'(e_wait));
        check("MemErr", MemErr, e_err);
        if (stall) begin
            waited++;
            if (e_wait < WMAX) e_wait++;
            e_bub = 1'b1;
            e_wen = 1'b1;
        end else begin
            e_bub = 1'b0;
            e_wen = m.wen; e_sel = m.sel; e_wa = m.wa; e_alu = m.alu; e_pc = m.pc;
            e_rd  = (acc && !m.drw && !tmo) ? rd : 32'd0;
            if (tmo) e_err = 1'b1;
            m = f ? bubble() : d;
            waited = 0;
        end
        consumed = !stall;
    endtask

    task automatic issue(input ins_t e, input bit fl);
        bit c;
        int n;
        n = 0;
        do begin
            run_cycle(e, fl, c);
            n++;
        end while (!c && n < 100);
        if (!c) check("issue_bound", 64'd0, 64'd1);
    endtask

    task automatic drain();
        issue(bubble(), 1'b0);
        issue(bubble(), 1'b0);
    endtask

    initial begin
        bit c;
        model_reset();
        drive(bubble(), 1'b0);
        bus.DRDY = 1'b0;
        bus.DRDATA = 32'd0;
        #1 RSTN = 1'b0;
        #2;
        check("rst_DREQ", bus.DREQ, 1'b1);
        check("rst_WEN_W", WEN_W, 1'b1);
        check("rst_StallM", StallM, 1'b0);
        check("rst_WaitCycles", WaitCycles, 0);
        check("rst_DADDR", bus.DADDR, 0);
        @(posedge CLK); #1 RSTN = 1'b1;

        // Zero-wait load, then a three-wait store.
        issue(mem_ins(1'b0, 32'h100, 32'h0, 0), 1'b0);
        drain();
        issue(mem_ins(1'b1, 32'h200, 32'h12345678, 3), 1'b0);
        drain();
        check("store_waits", WaitCycles, 3);

        // Flush while idle, then a two-wait load with flush pulses during its wait.
        issue(rand_ins(0), 1'b1);
        issue(mem_ins(1'b0, 32'h300, 32'h0, 2), 1'b0);
        drain();

        // Back-to-back zero-wait loads.
        issue(mem_ins(1'b0, 32'h400, 32'h0, 0), 1'b0);
        issue(mem_ins(1'b0, 32'h404, 32'h0, 0), 1'b0);
        drain();

`ifdef MEM_TIMEOUT_EN
        issue(mem_ins(1'b0, 32'h500, 32'h0, 40), 1'b0);
        drain();
        check("timeout_err", MemErr, 1'b1);
`endif

        for (int i = 0; i < 300; i++)
            issue(rand_ins(4), ($urandom_range(0, 7) == 0));
        drain();

        // Asynchronous reset in the middle of an outstanding access.
        issue(mem_ins(1'b0, 32'h600, 32'h0, 10), 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(bubble(), 1'b0, c);
        @(posedge CLK); #2;
        drive(bubble(), 1'b0);
        RSTN = 1'b0;
        #1;
        check("mid_rst_DREQ", bus.DREQ, 1'b1);
        check("mid_rst_WEN_W", WEN_W, 1'b1);
        check("mid_rst_StallM", StallM, 1'b0);
        check("mid_rst_WaitCycles", WaitCycles, 0);
        check("mid_rst_MemErr", MemErr, 1'b0);
        check("mid_rst_RDATA_W", RDATA_W, 0);
        model_reset();
        #1 RSTN = 1'b1;

        for (int i = 0; i < 40; i++)
            issue(rand_ins(3), ($urandom_range(0, 7) == 0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
